// File: rtl/mbinit_param_responder.sv
// Responder for the MBINIT.PARAM sideband exchange: checks the partner's request against local capabilities and returns the negotiated set.
// Optional partner retry while in DONE is enabled by defining MBINIT_PARAM_RESP_RETRY_EN.
module mbinit_param_responder #(
  parameter logic [3:0] REQ_ID         = 4'h1,
  parameter logic [3:0] RESP_ID        = 4'h2,
  parameter int         TIMEOUT_CYCLES = 8000,
  parameter int         CNT_W          = 13
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [2:0]  i_local_max_datarate,
  input  logic [1:0]  i_local_clock_mode,
  input  logic [1:0]  i_local_phase_clock,
  input  logic        i_rx_msg_valid,
  input  logic [3:0]  i_rx_msg_id,
  input  logic [15:0] i_rx_data,
  output logic        o_tx_msg_valid,
  input  logic        i_tx_ready,
  output logic [3:0]  o_tx_msg_id,
  output logic [15:0] o_tx_data,
  output logic [2:0]  o_neg_datarate,
  output logic [4:0]  o_neg_voltage_swing,
  output logic        o_done,
  output logic        o_error,
  output logic        o_timeout,
  output logic [2:0]  o_state
);

  // Response handshake: o_tx_msg_valid rises with o_tx_data/o_tx_msg_id already stable and
  // holds them unchanged until a cycle with i_tx_ready=1; the transfer completes on that
  // edge. Valid may also drop without a transfer when i_enable falls (abandoned response).

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_REQ  = 3'd1,
    CHECK     = 3'd2,
    SEND_RESP = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       req_q;

  logic              req_hit;
  logic [2:0]        p_rate;
  logic [1:0]        p_mode;
  logic [1:0]        p_phase;
  logic [4:0]        p_vswing;
  logic [2:0]        neg_rate;
  logic              mismatch;

  assign o_state  = state;
  assign req_hit  = i_rx_msg_valid && (i_rx_msg_id == REQ_ID);
  assign p_rate   = req_q[2:0];
  assign p_mode   = req_q[4:3];
  assign p_phase  = req_q[6:5];
  assign p_vswing = req_q[11:7];
  assign neg_rate = (p_rate < i_local_max_datarate) ? p_rate : i_local_max_datarate;
  assign mismatch = (p_mode != i_local_clock_mode) || (p_phase != i_local_phase_clock) ||
                    (p_vswing == 5'd0) || (req_q[15:12] != 4'd0);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      req_q               <= '0;
      o_tx_msg_valid      <= 1'b0;
      o_tx_msg_id         <= 4'd0;
      o_tx_data           <= 16'd0;
      o_neg_datarate      <= 3'd0;
      o_neg_voltage_swing <= 5'd0;
      o_done              <= 1'b0;
      o_error             <= 1'b0;
      o_timeout           <= 1'b0;
    end else if (state != IDLE && !i_enable) begin
      // Abort: negotiated results are deliberately retained.
      state          <= IDLE;
      o_tx_msg_valid <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable) begin
            state <= WAIT_REQ;
            cnt   <= '0;
          end
        end
        WAIT_REQ: begin
          if (req_hit) begin
            req_q <= i_rx_data;
            state <= CHECK;
          end else if (cnt == CNT_LAST) begin
            o_timeout <= 1'b1;
            state     <= ERROR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          if (mismatch) begin
            o_error <= 1'b1;
            o_done  <= 1'b0;
            state   <= ERROR;
          end else begin
            o_tx_data      <= {4'b0000, p_vswing, i_local_phase_clock, i_local_clock_mode, neg_rate};
            o_tx_msg_id    <= RESP_ID;
            o_tx_msg_valid <= 1'b1;
            state          <= SEND_RESP;
          end
        end
        SEND_RESP: begin
          if (i_tx_ready) begin
            o_tx_msg_valid      <= 1'b0;
            o_neg_datarate      <= o_tx_data[2:0];
            o_neg_voltage_swing <= o_tx_data[11:7];
            o_done              <= 1'b1;
            state               <= DONE;
          end
        end
        DONE: begin
`ifdef MBINIT_PARAM_RESP_RETRY_EN
          // Partner retry: re-check the fresh payload; o_done stays up meanwhile.
          if (req_hit) begin
            req_q <= i_rx_data;
            state <= CHECK;
          end
`endif
        end
        ERROR: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbinit_param_responder.sv
// Bench for mbinit_param_responder: vector table of request payloads plus sequences for
// backpressure, timeout, abort and retry; responses are checked against an expected queue.
module tb_mbinit_param_responder;

  localparam logic [3:0] REQ  = 4'h1;
  localparam logic [3:0] RESP = 4'h2;

  logic        CLK = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [2:0]  i_local_max_datarate;
  logic [1:0]  i_local_clock_mode;
  logic [1:0]  i_local_phase_clock;
  logic        i_rx_msg_valid;
  logic [3:0]  i_rx_msg_id;
  logic [15:0] i_rx_data;
  logic        o_tx_msg_valid;
  logic        i_tx_ready;
  logic [3:0]  o_tx_msg_id;
  logic [15:0] o_tx_data;
  logic [2:0]  o_neg_datarate;
  logic [4:0]  o_neg_voltage_swing;
  logic        o_done;
  logic        o_error;
  logic        o_timeout;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_e;

  typedef struct {
    logic [2:0]  lrate;
    logic [1:0]  lmode;
    logic [1:0]  lphase;
    logic [15:0] payload;
    logic        err;
    logic [15:0] resp;
    logic [2:0]  nrate;
    logic [4:0]  nvs;
  } vec_t;
  vec_t vecs[8];

  mbinit_param_responder #(
    .REQ_ID(REQ), .RESP_ID(RESP), .TIMEOUT_CYCLES(16), .CNT_W(5)
  ) dut (
    .CLK(CLK), .rst(rst), .i_enable(i_enable),
    .i_local_max_datarate(i_local_max_datarate),
    .i_local_clock_mode(i_local_clock_mode),
    .i_local_phase_clock(i_local_phase_clock),
    .i_rx_msg_valid(i_rx_msg_valid), .i_rx_msg_id(i_rx_msg_id), .i_rx_data(i_rx_data),
    .o_tx_msg_valid(o_tx_msg_valid), .i_tx_ready(i_tx_ready),
    .o_tx_msg_id(o_tx_msg_id), .o_tx_data(o_tx_data),
    .o_neg_datarate(o_neg_datarate), .o_neg_voltage_swing(o_neg_voltage_swing),
    .o_done(o_done), .o_error(o_error), .o_timeout(o_timeout), .o_state(o_state)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_local(input logic [2:0] r, input logic [1:0] m, input logic [1:0] p);
    i_local_max_datarate = r;
    i_local_clock_mode   = m;
    i_local_phase_clock  = p;
  endtask

  // Leaves the bench in the cycle after the request was sampled (CHECK cycle).
  task automatic send_req(input logic [3:0] id, input logic [15:0] d);
    i_rx_msg_valid = 1'b1;
    i_rx_msg_id    = id;
    i_rx_data      = d;
    tick();
    i_rx_msg_valid = 1'b0;
    i_rx_msg_id    = 4'h0;
    i_rx_data      = 16'h0;
  endtask

  task automatic enable_on();
    i_enable = 1'b1;
    tick();
    chk("enter_wait_req", o_state, 3'd1);
  endtask

  task automatic abort();
    i_enable = 1'b0;
    tick();
    chk("abort_state", o_state, 3'd0);
    chk("abort_flags", {o_tx_msg_valid, o_done, o_error, o_timeout}, 4'b0000);
  endtask

  // Scoreboard: every handshake pops one expected response
  always @(posedge CLK) begin
    #2;
    if (!rst && o_tx_msg_valid && i_tx_ready) begin
      hs_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp actual=%0h expected=none", o_tx_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (o_tx_data !== exp_e || o_tx_msg_id !== RESP) begin
          errors++;
          $display("FAIL resp_data actual=%0h/%0h expected=%0h/%0h",
                   o_tx_msg_id, o_tx_data, RESP, exp_e);
        end
      end
    end
  end

  initial begin
    int h0;
    vecs[0] = '{3'd3, 2'd0, 2'd1, 16'h0625, 1'b0, 16'h0623, 3'd3, 5'd12};
    vecs[1] = '{3'd6, 2'd2, 2'd3, 16'h0FF2, 1'b0, 16'h0FF2, 3'd2, 5'd31};
    vecs[2] = '{3'd7, 2'd1, 2'd0, 16'h008F, 1'b0, 16'h008F, 3'd7, 5'd1};
    vecs[3] = '{3'd3, 2'd0, 2'd1, 16'h062D, 1'b1, 16'h0000, 3'd7, 5'd1};
    vecs[4] = '{3'd3, 2'd0, 2'd1, 16'h0645, 1'b1, 16'h0000, 3'd7, 5'd1};
    vecs[5] = '{3'd3, 2'd0, 2'd1, 16'h0025, 1'b1, 16'h0000, 3'd7, 5'd1};
    vecs[6] = '{3'd3, 2'd0, 2'd1, 16'h1625, 1'b1, 16'h0000, 3'd7, 5'd1};
    vecs[7] = '{3'd4, 2'd3, 2'd2, 16'h0858, 1'b0, 16'h0858, 3'd0, 5'd16};

    rst = 1'b1; i_enable = 1'b0; i_rx_msg_valid = 1'b0; i_rx_msg_id = 4'h0;
    i_rx_data = 16'h0; i_tx_ready = 1'b0;
    set_local(3'd0, 2'd0, 2'd0);
    tick(); tick(); tick();
    chk("reset_state", o_state, 3'd0);
    chk("reset_outs", {o_tx_msg_valid, o_tx_msg_id, o_tx_data, o_neg_datarate,
                       o_neg_voltage_swing, o_done, o_error, o_timeout}, 32'd0);
    rst = 1'b0;
    tick();

    // Vector table, i_tx_ready tied high
    for (int i = 0; i < 8; i++) begin
      set_local(vecs[i].lrate, vecs[i].lmode, vecs[i].lphase);
      i_tx_ready = 1'b1;
      if (!vecs[i].err) exp_q.push_back(vecs[i].resp);
      enable_on();
      send_req(REQ, vecs[i].payload);
      chk("vec_check_state", o_state, 3'd2);
      tick();
      if (vecs[i].err) begin
        chk("vec_error", {o_error, o_tx_msg_valid, o_state}, {1'b1, 1'b0, 3'd5});
      end else begin
        chk("vec_valid", {o_tx_msg_valid, o_state}, {1'b1, 3'd3});
        chk("vec_data", o_tx_data, vecs[i].resp);
      end
      tick();
      chk("vec_done", {o_done, o_error, o_tx_msg_valid}, {~vecs[i].err, vecs[i].err, 1'b0});
      chk("vec_neg", {o_neg_datarate, o_neg_voltage_swing}, {vecs[i].nrate, vecs[i].nvs});
      abort();
    end

    // Backpressure: ready low for 5 valid cycles
    set_local(3'd3, 2'd0, 2'd1);
    i_tx_ready = 1'b0;
    enable_on();
    exp_q.push_back(16'h0623);
    h0 = hs_count;
    send_req(REQ, 16'h0625);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", {o_tx_msg_valid, o_done}, 2'b10);
      chk("bp_data", o_tx_data, 16'h0623);
      if (i < 5) tick();
    end
    i_tx_ready = 1'b1;
    tick();
    chk("bp_done", {o_done, o_tx_msg_valid}, 2'b10);
    chk("bp_single_hs", hs_count, h0 + 1);
    abort();

    // Timeout with only foreign IDs, one landing on the last counter value
    enable_on();
    for (int k = 1; k <= 16; k++) begin
      if (k == 3 || k == 16) begin
        i_rx_msg_valid = 1'b1; i_rx_msg_id = 4'h3; i_rx_data = 16'h0625;
      end
      tick();
      i_rx_msg_valid = 1'b0; i_rx_msg_id = 4'h0;
      if (k < 16) chk("to_early", o_timeout, 1'b0);
    end
    chk("to_flag", {o_timeout, o_error, o_state}, {1'b1, 1'b0, 3'd5});
    tick();
    chk("to_hold", o_timeout, 1'b1);
    abort();

    // Request on the final timeout cycle wins
    enable_on();
    for (int k = 1; k <= 15; k++) tick();
    exp_q.push_back(16'h0623);
    send_req(REQ, 16'h0625);
    chk("race_check", {o_timeout, o_state}, {1'b0, 3'd2});
    tick(); tick();
    chk("race_done", {o_done, o_timeout}, 2'b10);
    abort();

    // Abort during SEND_RESP, then a clean exchange
    i_tx_ready = 1'b0;
    set_local(3'd6, 2'd2, 2'd3);
    enable_on();
    send_req(REQ, 16'h0FF2);
    tick();
    chk("ab_sending", {o_tx_msg_valid, o_state}, {1'b1, 3'd3});
    abort();
    chk("ab_neg_kept", {o_neg_datarate, o_neg_voltage_swing}, {3'd3, 5'd12});
    set_local(3'd3, 2'd0, 2'd1);
    i_tx_ready = 1'b1;
    exp_q.push_back(16'h0623);
    enable_on();
    send_req(REQ, 16'h0625);
    tick(); tick();
    chk("ab_redo_done", {o_done, o_state}, {1'b1, 3'd4});

    // Retry while in DONE
    h0 = hs_count;
`ifdef MBINIT_PARAM_RESP_RETRY_EN
    exp_q.push_back(16'h0623);
`endif
    send_req(REQ, 16'h0625);
    chk("rt_done0", o_done, 1'b1);
    tick();
    chk("rt_done1", o_done, 1'b1);
    tick();
    chk("rt_done2", {o_done, o_tx_msg_valid, o_state}, {1'b1, 1'b0, 3'd4});
`ifdef MBINIT_PARAM_RESP_RETRY_EN
    chk("rt_hs", hs_count, h0 + 1);
    send_req(REQ, 16'h062D);
    tick();
    chk("rt_mismatch", {o_done, o_error, o_state}, {1'b0, 1'b1, 3'd5});
`else
    chk("rt_no_hs", hs_count, h0);
`endif
    abort();

    tick(); tick();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbinit_param_responder.md
Name: mbinit_param_responder

Overview:
- Responder side of the MBINIT.PARAM exchange.
- Waits for the partner's sideband PARAM request and checks the partner's advertised capabilities against the local capability register outputs.
- Computes the negotiated parameter set and returns it as a sideband PARAM response using a valid/ready handshake.
- Sits between the sideband message decoder/encoder and the MBINIT LTSM substate controller.

Parameters:
- REQ_ID, 4'h1, sideband message ID of the partner PARAM request.
- RESP_ID, 4'h2, sideband message ID of the PARAM response sent by this block.
- TIMEOUT_CYCLES, 8000, cycles to wait for a request before flagging timeout.
- CNT_W, 13, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  block clock
- rst  in  1  synchronous, active-high reset
- i_enable  in  1  LTSM in MBINIT.PARAM; level; deassertion aborts
- i_local_max_datarate  in  3  local max data rate code
- i_local_clock_mode  in  2  local clock mode
- i_local_phase_clock  in  2  local clock phase
- i_rx_msg_valid  in  1  decoded sideband message present (1-cycle pulse)
- i_rx_msg_id  in  4  decoded message ID
- i_rx_data  in  16  payload: [2:0] rate, [4:3] clock mode, [6:5] phase, [11:7] voltage swing, [15:12] reserved
- o_tx_msg_valid  out  1  response valid
- i_tx_ready  in  1  encoder accepts response
- o_tx_msg_id  out  4  response ID
- o_tx_data  out  16  response payload, same field layout as i_rx_data
- o_neg_datarate  out  3  negotiated data rate
- o_neg_voltage_swing  out  5  accepted partner voltage swing
- o_done  out  1  exchange complete (level, until i_enable falls)
- o_error  out  1  capability mismatch (level)
- o_timeout  out  1  no request in time (level)

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0; holding registers 0.
- States: IDLE, WAIT_REQ, CHECK, SEND_RESP, DONE, ERROR.
- IDLE: when i_enable=1, go to WAIT_REQ and clear the counter.
- WAIT_REQ:
  - Counter increments each cycle.
  - When i_rx_msg_valid=1 and i_rx_msg_id==REQ_ID, latch i_rx_data and go to CHECK.
  - Messages with any other ID are ignored and do not reset the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no request, set o_timeout=1 and go to ERROR.
  - If a request arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1, the request wins.
- CHECK (exactly 1 cycle):
  - negotiated rate = min(partner rate, i_local_max_datarate), unsigned compare.
  - Mismatch if partner clock mode != local, or partner phase != local, or partner voltage swing == 0, or reserved bits != 0.
  - Mismatch: set o_error=1, go to ERROR, send no response.
  - Otherwise: register o_tx_data = {4'b0, partner vswing, local phase, local clock mode, negotiated rate}; o_tx_msg_id=RESP_ID; go to SEND_RESP.
- SEND_RESP:
  - o_tx_msg_valid=1 and o_tx_data held stable until i_tx_ready=1.
  - On handshake: drop valid on the next cycle, update o_neg_datarate and o_neg_voltage_swing, set o_done=1, go to DONE.
- Latency: request accepted in cycle N; CHECK in N+1; o_tx_msg_valid high from N+2. With i_tx_ready tied high, o_done is high at N+3.
- DONE and ERROR: hold the flags. New requests are ignored (see Optional Feature).
- i_enable=0 in any non-IDLE state:
  - Next cycle: state IDLE; o_tx_msg_valid, o_done, o_error, o_timeout all cleared.
  - o_neg_datarate and o_neg_voltage_swing keep their last values.
  - An in-flight response is abandoned; the encoder must tolerate valid dropping.
- rst has priority over all other inputs.

Optional Feature:
- Macro: MBINIT_PARAM_RESP_RETRY_EN.
- Defined:
  - In DONE, a further REQ_ID request is treated as a partner retry. The block relatches the payload and returns to CHECK, keeping o_done=1 until the new handshake or an error.
  - If the retry payload mismatches, o_done clears and o_error sets.
- Undefined: requests received in DONE are ignored.

Test Plan:
- Match:
  - Stimulus: local rate=3, mode=0, phase=1; request payload rate=5, mode=0, phase=1, vswing=12; i_tx_ready=1.
  - Response: o_tx_data=16'h0623 at N+2; o_neg_datarate=3; o_neg_voltage_swing=12; o_done=1 at N+3.
- Backpressure:
  - Stimulus: same request as above; i_tx_ready held 0 for 5 cycles.
  - Response: valid and data stable for 6 cycles; single handshake; o_done on the cycle after ready rises.
- Mismatch:
  - Stimulus: request with clock mode=1 against local mode=0.
  - Response: o_error=1 at N+2; o_tx_msg_valid never asserted.
- Timeout and ID filtering:
  - Stimulus: TIMEOUT_CYCLES=16; only a message with ID 4'h3 sent.
  - Response: o_timeout=1 exactly 16 cycles after entering WAIT_REQ.
- Abort:
  - Stimulus: drop i_enable during SEND_RESP with i_tx_ready=0.
  - Response: next cycle valid=0, state IDLE, flags=0; re-enabling and sending a valid request completes normally.
- Retry (macro defined):
  - Stimulus: second identical request while in DONE.
  - Response: second response sent with identical data; o_done remains 1 throughout.
  - Same stimulus with macro undefined: no second response.
